// File: rtl/pattern_gen_wb.sv
// rtl/pattern_gen_wb.sv - Wishbone-slave pattern generator with FIXED/INCR/WALK/LFSR modes
module pattern_gen_wb #(
  parameter int ADDR_WIDTH          = 12,
  parameter int DATA_WIDTH          = 14,
  parameter int NUM_REGS            = 4,
  parameter int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_ni,
  input  logic                           wb_si_cyc_i,
  input  logic                           wb_si_stb_i,
  input  logic                           wb_si_we_i,
  input  logic [ADDR_WIDTH-1:0]          wb_si_adr_i,
  input  logic [DATA_WIDTH-1:0]          wb_si_dat_i,
  output logic [DATA_WIDTH-1:0]          wb_si_dat_o,
  output logic                           wb_si_ack_o,
  input  logic                           cfg_pat_gen_i,
  output logic [SUB_REGS_DATA_WIDTH-1:0] pg_data_o,
  output logic                           pg_valid_o,
  input  logic                           pg_ready_i,
  output logic                           nopg_o
);

  localparam int W  = SUB_REGS_DATA_WIDTH;
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [DATA_WIDTH-1:0] D_ONE = DATA_WIDTH'(1);
  localparam logic [W-1:0]          W_ONE = W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Programmer-visible registers
  logic                  r_en;
  logic [1:0]            r_mode;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_len;
  logic [DATA_WIDTH-1:0] r_count;
  logic [W-1:0]          r_pat [NUM_REGS];

  // Snapshot taken at LOAD; the active run only looks at these
  logic [1:0]            r_wmode;
  logic [DATA_WIDTH-1:0] r_wlen;
  logic [W-1:0]          r_wpat [NUM_REGS];

  // Stream state
  logic [IW-1:0]         r_idx;
  logic [W-1:0]          r_data;
  logic                  r_valid;

  // Bus response
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_req;
  logic                  w_wr;
  logic                  w_busy;
  logic                  w_sel_ctrl;
  logic                  w_sel_len;
  logic                  w_beat;
  logic                  w_last_beat;
  logic                  w_abort;
  logic [DATA_WIDTH-1:0] w_count_inc;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [W-1:0]          w_wdat_ext;
  logic [W-1:0]          w_first_word;
  logic [W-1:0]          w_next_word;

  assign w_req       = wb_si_cyc_i & wb_si_stb_i & ~r_ack;
  assign w_wr        = w_req & wb_si_we_i;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_sel_ctrl  = (wb_si_adr_i == ADDR_WIDTH'(0));
  assign w_sel_len   = (wb_si_adr_i == ADDR_WIDTH'(1));
  assign w_beat      = r_valid & pg_ready_i;
  assign w_count_inc = r_count + D_ONE;
  assign w_last_beat = w_beat && (r_wlen != '0) && (w_count_inc == r_wlen);
  assign w_abort     = ~r_en | ~cfg_pat_gen_i;

  assign wb_si_ack_o = r_ack;
  assign wb_si_dat_o = r_rdata;
  assign pg_data_o   = r_data;
  assign pg_valid_o  = r_valid;
  assign nopg_o      = ~w_busy;

  // Zero-extend bus write data to the pattern word width
  always_comb begin
    w_wdat_ext = '0;
    w_wdat_ext[DATA_WIDTH-1:0] = wb_si_dat_i;
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    w_rdata = '0;
    if (w_sel_ctrl) begin
      w_rdata[2:0] = {r_mode, r_en};
    end else if (w_sel_len) begin
      w_rdata = r_len;
    end else if (wb_si_adr_i == ADDR_WIDTH'(2)) begin
      w_rdata[1:0] = {r_done, w_busy};
    end else if (wb_si_adr_i == ADDR_WIDTH'(3)) begin
      w_rdata = r_count;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_si_adr_i == ADDR_WIDTH'(4 + i)) begin
        w_rdata = r_pat[i][DATA_WIDTH-1:0];
      end
    end
  end

  // First word of a run, from the live registers at LOAD time
  always_comb begin
    w_first_word = r_pat[0];
    case (r_mode)
      2'd2:    w_first_word = W_ONE;
      2'd3:    w_first_word = (r_pat[0] == '0) ? W_ONE : r_pat[0];
      default: w_first_word = r_pat[0];
    endcase
  end

  // Word presented after a beat, from the snapshot of the current run
  always_comb begin
    w_next_word = r_data;
    case (r_wmode)
      2'd0:    w_next_word = r_wpat[r_idx];
      2'd1:    w_next_word = r_data + W_ONE;
      2'd2:    w_next_word = {r_data[W-2:0], r_data[W-1]};
      default: w_next_word = r_data[0] ? ((r_data >> 1) ^ r_wpat[1]) : (r_data >> 1);
    endcase
  end

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a pending word is never withdrawn, so abort waits for its beat
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (r_en && cfg_pat_gen_i) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_last_beat || (w_abort && (w_beat || !r_valid))) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus handshake: one wait cycle, never two acks in a row
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= (w_req && !wb_si_we_i) ? w_rdata : '0;
    end
  end

  // Register writes; completion clears en and sets done, winning over clr_done
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_en   <= 1'b0;
      r_mode <= 2'd0;
      r_done <= 1'b0;
      r_len  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_pat[i] <= '0;
      end
    end else begin
      if (w_wr && w_sel_ctrl) begin
        r_mode <= wb_si_dat_i[2:1];
        if (!w_busy || !wb_si_dat_i[0]) begin
          r_en <= wb_si_dat_i[0];
        end
      end
      if (w_last_beat) begin
        r_en <= 1'b0;
      end
      if (w_wr && w_sel_len) begin
        r_len <= wb_si_dat_i;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr && (wb_si_adr_i == ADDR_WIDTH'(4 + i))) begin
          r_pat[i] <= w_wdat_ext;
        end
      end
      if (w_last_beat) begin
        r_done <= 1'b1;
      end else if (w_wr && w_sel_ctrl && wb_si_dat_i[3]) begin
        r_done <= 1'b0;
      end
    end
  end

  // Stream datapath: snapshot at LOAD, advance on each beat
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wmode <= 2'd0;
      r_wlen  <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_wpat[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_wmode <= r_mode;
          r_wlen  <= r_len;
          r_wpat  <= r_pat;
          r_count <= '0;
          r_data  <= w_first_word;
          r_idx   <= IW'(1);
          r_valid <= 1'b1;
        end
        ST_RUN: begin
          if (w_beat) begin
            r_count <= w_count_inc;
            if (w_state_nxt == ST_IDLE) begin
              r_valid <= 1'b0;
            end else begin
              r_data <= w_next_word;
              r_idx  <= (r_idx == IW'(NUM_REGS - 1)) ? '0 : r_idx + IW'(1);
            end
          end else if (w_state_nxt == ST_IDLE) begin
            r_valid <= 1'b0;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

endmodule
